// File: rtl/fc_operand_feeder_if.sv
// Bundle of the operand stream, fc engine handshake and result port of fc_operand_feeder.
// master = the feeder itself, slave = the DMA / fc engine / result sink side.
interface fc_operand_feeder_if #(
   parameter int N  = 9,
   parameter int DW = 8,
   parameter int RW = 16
);
   // Valid/ready: a beat or result transfers on the rising edge where valid and ready are
   // both 1; the source holds its payload stable and keeps valid up until that edge.
   logic            s_valid;
   logic            s_ready;
   logic [DW-1:0]   s_act;
   logic [DW-1:0]   s_wgt;
   logic            s_last;
   logic [N*DW-1:0] fc_act;
   logic [N*DW-1:0] fc_wgt;
   logic            fc_enable;
   logic            fc_done;
   logic [RW-1:0]   fc_result;
   logic            m_valid;
   logic            m_ready;
   logic [RW-1:0]   m_data;
   logic [1:0]      err;

   modport master (
      input  s_valid, s_act, s_wgt, s_last, fc_done, fc_result, m_ready,
      output s_ready, fc_act, fc_wgt, fc_enable, m_valid, m_data, err
   );

   modport slave (
      output s_valid, s_act, s_wgt, s_last, fc_done, fc_result, m_ready,
      input  s_ready, fc_act, fc_wgt, fc_enable, m_valid, m_data, err
   );
endinterface

// File: rtl/fc_operand_feeder.sv
// Buffers one frame of signed (act, wgt) pairs, runs the fc enable/done handshake and returns
// the result. Define FC_FEEDER_RELU_EN to clamp negative captured results to zero.
module fc_operand_feeder #(
   parameter int N   = 9,
   parameter int DW  = 8,
   parameter int RW  = 16,
   parameter int TMO = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   fc_operand_feeder_if.master      bus,
   output logic [1:0]               dbg_state
);
   localparam int CW = $clog2(N);
   localparam int TW = $clog2(TMO);

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      OUT   = 2'd3
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [CW-1:0]   count;
   logic [TW-1:0]   timer;
   logic [DW-1:0]   act_buf [N];
   logic [DW-1:0]   wgt_buf [N];
   logic            s_ready_q;
   logic            fc_enable_q;
   logic            m_valid_q;
   logic [RW-1:0]   m_data_q;
   logic [RW-1:0]   result_cap;
   logic [1:0]      err_q;

   logic accept;
   logic at_end;
   logic close;
   logic done_hit;
   logic tmo_hit;
   logic out_fire;

   assign accept   = bus.s_valid & s_ready_q;
   assign at_end   = (count == CW'(N - 1));
   assign close    = accept & (bus.s_last | at_end);
   assign done_hit = (state == WAIT) & bus.fc_done;
   assign tmo_hit  = (state == WAIT) & ~bus.fc_done & (timer == TW'(TMO - 1));
   assign out_fire = (state == OUT) & m_valid_q & bus.m_ready;

   always_comb begin
      state_next = state;
      case (state)
         LOAD:    if (close) state_next = ISSUE;
         ISSUE:   state_next = WAIT;
         WAIT:    if (done_hit || tmo_hit) state_next = OUT;
         OUT:     if (out_fire) state_next = LOAD;
         default: state_next = LOAD;
      endcase
   end

   always_comb begin
      result_cap = bus.fc_result;
`ifdef FC_FEEDER_RELU_EN
      if (bus.fc_result[RW-1]) result_cap = '0;
`else
      result_cap = bus.fc_result;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= LOAD;
      else      state <= state_next;
   end

   // Handshake outputs are flops decoded from the next state, so they never glitch.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s_ready_q   <= 1'b0;
         fc_enable_q <= 1'b0;
         m_valid_q   <= 1'b0;
      end else begin
         s_ready_q   <= (state_next == LOAD);
         fc_enable_q <= (state_next == WAIT);
         m_valid_q   <= (state_next == OUT);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (out_fire) begin
         count <= '0;
      end else if (accept && !close) begin
         count <= count + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         timer <= '0;
      end else if (state != WAIT) begin
         timer <= '0;
      end else begin
         timer <= timer + 1'b1;
      end
   end

   // A short frame zeroes every slot above the closing beat.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N; i++) begin
            act_buf[i] <= '0;
            wgt_buf[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (out_fire) begin
               act_buf[i] <= '0;
               wgt_buf[i] <= '0;
            end else if (accept && (CW'(i) == count)) begin
               act_buf[i] <= bus.s_act;
               wgt_buf[i] <= bus.s_wgt;
            end else if (close && (CW'(i) > count)) begin
               act_buf[i] <= '0;
               wgt_buf[i] <= '0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_data_q <= '0;
      end else if (done_hit) begin
         m_data_q <= result_cap;
      end else if (tmo_hit) begin
         m_data_q <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= 2'b00;
      end else begin
         if (close && !(at_end && bus.s_last)) err_q[0] <= 1'b1;
         if (tmo_hit)                          err_q[1] <= 1'b1;
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_pack
      assign bus.fc_act[g*DW +: DW] = act_buf[g];
      assign bus.fc_wgt[g*DW +: DW] = wgt_buf[g];
   end

   assign bus.s_ready   = s_ready_q;
   assign bus.fc_enable = fc_enable_q;
   assign bus.m_valid   = m_valid_q;
   assign bus.m_data    = m_data_q;
   assign bus.err       = err_q;
   assign dbg_state     = state;
endmodule

// File: tb/tb_fc_operand_feeder.sv
// Directed bench for fc_operand_feeder: a vector table of whole frames plus hand-written
// sequences for result back-pressure and reset during the engine wait.
module tb_fc_operand_feeder;
   localparam int N   = 9;
   localparam int DW  = 8;
   localparam int RW  = 16;
   localparam int TMO = 64;
   localparam int W   = N * DW;
`ifdef FC_FEEDER_RELU_EN
   localparam bit RELU = 1'b1;
`else
   localparam bit RELU = 1'b0;
`endif

   typedef struct {
      int          nb;
      int          act0;
      int          act_step;
      int          wgt;
      bit          last_ok;
      int          lat;
      logic [15:0] res;
      int          rdy_delay;
      logic [15:0] exp_data;
      logic [1:0]  exp_err;
      int          exp_en;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic [1:0] dbg_state;

   fc_operand_feeder_if #(.N(N), .DW(DW), .RW(RW)) bus ();

   fc_operand_feeder #(.N(N), .DW(DW), .RW(RW), .TMO(TMO)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          eng_lat  = -1;
   logic [15:0] eng_res  = 16'h0;
   int          en_cnt   = 0;
   int          en_total = 0;

   // Engine model: raises fc_done for one cycle once fc_enable has been high eng_lat cycles.
   always @(posedge clk) begin
      #1;
      if (bus.fc_enable) begin
         en_cnt++;
         en_total++;
      end else begin
         en_cnt = 0;
      end
      bus.fc_done   = bus.fc_enable && (eng_lat >= 0) && (en_cnt == eng_lat + 1);
      bus.fc_result = bus.fc_done ? eng_res : 16'hDEAD;
   end

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic exp_bus(input int nb, input int a0, input int step, input int w,
                          output logic [W-1:0] ea, output logic [W-1:0] ew);
      int ta;
      int tw;
      ea = '0;
      ew = '0;
      for (int i = 0; i < nb; i++) begin
         ta = a0 + step * i;
         tw = w;
         ea[i*DW +: DW] = ta[7:0];
         ew[i*DW +: DW] = tw[7:0];
      end
   endtask

   task automatic send_frame(input int nb, input int a0, input int step, input int w,
                             input bit last_ok);
      int ta;
      int tw;
      int guard;
      for (int i = 0; i < nb; i++) begin
         @(negedge clk);
         ta = a0 + step * i;
         tw = w;
         bus.s_valid = 1'b1;
         bus.s_act   = ta[7:0];
         bus.s_wgt   = tw[7:0];
         bus.s_last  = last_ok && (i == nb - 1);
         guard = 0;
         while (!bus.s_ready && guard < 50) begin
            @(negedge clk);
            guard++;
         end
         if (!bus.s_ready) chk("s_ready_wait", W'(bus.s_ready), W'(1));
         @(posedge clk);
      end
   endtask

   task automatic wait_m_valid(input int budget);
      int guard;
      guard = 0;
      while (!bus.m_valid && guard < budget) begin
         @(negedge clk);
         guard++;
      end
      chk("m_valid_seen", W'(bus.m_valid), W'(1));
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      logic [W-1:0] ea;
      logic [W-1:0] ew;
      int en_start;
      eng_lat     = v.lat;
      eng_res     = v.res;
      bus.m_ready = 1'b0;
      en_start    = en_total;
      send_frame(v.nb, v.act0, v.act_step, v.wgt, v.last_ok);
      @(negedge clk);
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      exp_bus(v.nb, v.act0, v.act_step, v.wgt, ea, ew);
      chk($sformatf("v%0d_s_ready_closed", idx), W'(bus.s_ready), W'(0));
      chk($sformatf("v%0d_state_issue", idx), W'(dbg_state), W'(1));
      chk($sformatf("v%0d_fc_act", idx), bus.fc_act, ea);
      chk($sformatf("v%0d_fc_wgt", idx), bus.fc_wgt, ew);
      wait_m_valid(200);
      chk($sformatf("v%0d_enable_cycles", idx), W'(en_total - en_start), W'(v.exp_en));
      chk($sformatf("v%0d_fc_enable_low", idx), W'(bus.fc_enable), W'(0));
      chk($sformatf("v%0d_m_data", idx), W'(bus.m_data), W'(v.exp_data));
      chk($sformatf("v%0d_err", idx), W'(bus.err), W'(v.exp_err));
      for (int i = 0; i < v.rdy_delay; i++) begin
         @(negedge clk);
         chk($sformatf("v%0d_hold_valid", idx), W'(bus.m_valid), W'(1));
         chk($sformatf("v%0d_hold_data", idx), W'(bus.m_data), W'(v.exp_data));
      end
      bus.m_ready = 1'b1;
      @(negedge clk);
      bus.m_ready = 1'b0;
      chk($sformatf("v%0d_m_valid_drop", idx), W'(bus.m_valid), W'(0));
      chk($sformatf("v%0d_s_ready_back", idx), W'(bus.s_ready), W'(1));
      chk($sformatf("v%0d_buf_cleared", idx), bus.fc_act | bus.fc_wgt, W'(0));
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = '{9, 1, 1, 2, 1'b1, 3, 16'd90, 2, 16'd90, 2'b00, 4};
      vecs[1] = '{9, -3, 0, 7, 1'b1, 0, 16'hFF43, 0, RELU ? 16'h0 : 16'hFF43, 2'b00, 1};
      vecs[2] = '{9, 10, -1, -4, 1'b1, 5, 16'hFFF9, 3, RELU ? 16'h0 : 16'hFFF9, 2'b00, 6};
      vecs[3] = '{9, 0, 3, 1, 1'b0, 2, 16'h04D2, 0, 16'h04D2, 2'b01, 3};
      vecs[4] = '{4, 5, 0, 5, 1'b1, 1, 16'd100, 1, 16'd100, 2'b01, 2};
      vecs[5] = '{9, 1, 1, 1, 1'b1, -1, 16'h1234, 0, 16'h0000, 2'b11, TMO};

      bus.s_valid = 1'b0;
      bus.s_act   = '0;
      bus.s_wgt   = '0;
      bus.s_last  = 1'b0;
      bus.m_ready = 1'b0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_s_ready", W'(bus.s_ready), W'(0));
      chk("rst_fc_enable", W'(bus.fc_enable), W'(0));
      chk("rst_m_valid", W'(bus.m_valid), W'(0));
      chk("rst_m_data", W'(bus.m_data), W'(0));
      chk("rst_err", W'(bus.err), W'(0));
      chk("rst_state", W'(dbg_state), W'(0));
      chk("rst_buffers", bus.fc_act | bus.fc_wgt, W'(0));
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_s_ready", W'(bus.s_ready), W'(1));

      for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

      // Result held back 20 cycles while the next beat waits on the input.
      begin
         logic [W-1:0] ea;
         logic [W-1:0] ew;
         eng_lat = 2;
         eng_res = 16'h0321;
         send_frame(9, 1, 1, 2, 1'b1);
         @(negedge clk);
         bus.s_valid = 1'b0;
         bus.s_last  = 1'b0;
         wait_m_valid(200);
         bus.s_valid = 1'b1;
         bus.s_act   = 8'd42;
         bus.s_wgt   = 8'hFF;
         bus.s_last  = 1'b1;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("stall_s_ready", W'(bus.s_ready), W'(0));
            chk("stall_m_valid", W'(bus.m_valid), W'(1));
            chk("stall_m_data", W'(bus.m_data), W'(16'h0321));
         end
         eng_lat = 0;
         eng_res = 16'd5;
         bus.m_ready = 1'b1;
         @(negedge clk);
         bus.m_ready = 1'b0;
         chk("stall_release_valid", W'(bus.m_valid), W'(0));
         chk("stall_release_ready", W'(bus.s_ready), W'(1));
         @(negedge clk);
         bus.s_valid = 1'b0;
         bus.s_last  = 1'b0;
         exp_bus(1, 42, 0, -1, ea, ew);
         chk("held_beat_act", bus.fc_act, ea);
         chk("held_beat_wgt", bus.fc_wgt, ew);
         chk("held_beat_state", W'(dbg_state), W'(1));
         wait_m_valid(200);
         chk("held_beat_m_data", W'(bus.m_data), W'(16'd5));
         chk("held_beat_err", W'(bus.err), W'(2'b11));
         bus.m_ready = 1'b1;
         @(negedge clk);
         bus.m_ready = 1'b0;
         chk("held_beat_done", W'(bus.m_valid), W'(0));
      end

      // Asynchronous reset while the engine is being waited on.
      eng_lat = -1;
      send_frame(9, 1, 1, 2, 1'b1);
      @(negedge clk);
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      repeat (5) @(negedge clk);
      chk("wait_fc_enable", W'(bus.fc_enable), W'(1));
      chk("wait_state", W'(dbg_state), W'(2));
      #2 rst = 1'b0;
      #1;
      chk("arst_fc_enable", W'(bus.fc_enable), W'(0));
      chk("arst_m_valid", W'(bus.m_valid), W'(0));
      chk("arst_err", W'(bus.err), W'(0));
      chk("arst_s_ready", W'(bus.s_ready), W'(0));
      chk("arst_buffers", bus.fc_act | bus.fc_wgt, W'(0));
      chk("arst_state", W'(dbg_state), W'(0));
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("arst_s_ready_back", W'(bus.s_ready), W'(1));
      run_vec(vecs[0], 6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
